expr_pipe_lanes: RTL
====================

Name: expr_pipe_lanes

Overview:
- Multi-lane, pipelined successor to the flat mixed-signedness expression blocks.
- Each of LANES lanes evaluates one opcode-selected expression on W-bit operands, with per-lane signedness.
- Results travel through a STAGES-deep elastic pipeline with valid/ready handshake.
- Used as a regression target for width/sign-extension semantics with real sequential behaviour, and as a reusable arithmetic lane array.

Parameters:
- W, 6, operand/result width per lane (>=2).
- LANES, 3, number of independent lanes.
- STAGES, 2, register stages from input accept to output (>=1).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept this cycle.
- in_op  in  3*LANES  per-lane opcode; lane i uses bits [3i+2:3i].
- in_sgn  in  LANES  per-lane signed-mode flag (1 = two's-complement).
- in_a  in  W*LANES  per-lane operand a.
- in_b  in  W*LANES  per-lane operand b.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts.
- out_y  out  W*LANES  per-lane results, lane 0 in the LSBs.
- out_ovf  out  LANES  per-lane overflow flag for the same transaction.
- out_cnt  out  CNT_W  completed output handshakes, wraps modulo 2^CNT_W.

Behaviour:
- Reset values: out_valid=0, out_y=0, out_ovf=0, out_cnt=0, all stage valids=0. in_ready=1 in the cycle after reset deasserts.
- reset mid-operation: every in-flight transaction is dropped with no output; the counter clears; reset wins over a simultaneous handshake.
- Accept: in_valid & in_ready. Fire: out_valid & out_ready; out_cnt increments on each fire.
- Stage 0 computes all lanes; stages 1..STAGES-1 only delay the results.
- Latency: STAGES cycles from accept to out_valid while out_ready is held high.
- Throughput: 1 transaction per cycle.
- Stage k advances if it is empty or stage k+1 advances. in_ready = stage 0 empty or stage 0 advancing (combinational). No bubbles are inserted and no data is lost under backpressure.
- While out_valid=1 and out_ready=0, out_y, out_ovf and out_valid hold stable.
- Operand interpretation: signed if in_sgn[i] else unsigned. All intermediates are computed at 2W+1 bits with the matching extension; the result is the low W bits.
- Opcodes:
  - 0 ADD a+b.
  - 1 SUB a-b.
  - 2 MUL a*b, low W bits.
  - 3 SHL a<<b[clog2(W):0]; shift >= W gives 0.
  - 4 SHR: arithmetic if signed, else logical; shift >= W gives all sign bits (signed) or 0.
  - 5 LT: result is 1 if a<b, else 0; zero-extended.
  - 6 XNOR a~^b.
  - 7 SEL: (a!=0) ? b : ~b.
- out_ovf[i]: set only for ADD/SUB/MUL when the full-precision result is outside the W-bit range of the lane's signedness; 0 for all other opcodes.
- Lanes are fully independent; a mixed opcode/sign vector is legal.

Optional Feature:
- Macro EXPR_PIPE_SAT_EN.
- Defined: ADD/SUB/MUL results that overflow saturate to max or min of the lane's signedness. Examples: unsigned W=6 clamps to 63 or 0; signed clamps to 31 or -32. out_ovf still reports the overflow.
- Undefined: results wrap (low W bits); out_ovf is unchanged.

Decomposition:
- Package expr_pipe_pkg: opcode localparams OP_ADD..OP_SEL, a function for the shift-amount width, and a saturation-bound helper function.
- One sub-module, expr_lane: combinational single-lane evaluator (W, op, sgn, a, b -> y, ovf), instantiated LANES times.
- The top level holds the elastic pipeline registers and the counter.

Test Plan:
- Reset mid-stream: issue 2 transactions, assert reset for 1 cycle before they emerge -> no out_valid, out_cnt=0, in_ready=1 next cycle.
- Latency/throughput, STAGES=2: back-to-back accepts with lane0 ADD unsigned a=5,b=7, out_ready=1 -> y lane0=12, out_valid exactly 2 cycles after first accept, one result per cycle, out_cnt counts 1,2,3...
- Sign semantics, W=6: lane0 SHR signed a=6'b100000,b=2 -> 6'b111000; lane1 SHR unsigned same operands -> 6'b001000; lane2 LT signed a=-1,b=1 -> 1 (unsigned: 0).
- Overflow: unsigned ADD 40+30 -> y=6, ovf=1 (with EXPR_PIPE_SAT_EN: y=63, ovf=1). Signed MUL -8*5 -> y=24, ovf=1 (SAT: -32). Signed SUB 3-5 -> y=-2, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles with continuous in_valid -> in_ready drops after STAGES accepts; out_y stable. Release -> all accepted results emerge in order, none lost or duplicated.
- Corners: SHL by 6 and by 7 -> 0. SEL a=0,b=6'h15 -> 6'h2A. XNOR a=b -> 6'h3F. CNT_W=4 counter wraps 15 -> 0 after 16 fires.

Source files
------------

// File: rtl/expr_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : expr_pipe_pkg
//  Description : Shared opcode encodings and helper functions for the
//                expr_pipe_lanes lane array.
//                OP_ADD..OP_SEL   3-bit lane opcodes
//                shamt_w()        width of the shift-amount field of operand b
//                sat_bound()      saturation limit for a lane's signedness
//                                 (used when EXPR_PIPE_SAT_EN is defined)
//  Revision    : 1.0 - initial release
// ============================================================================
package expr_pipe_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_LT   = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_SEL  = 3'd7;

    // Shift amount is b[clog2(w):0], i.e. one bit wider than needed to
    // express w-1, so that shifts >= w are observable.
    function automatic int shamt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    // Saturation limit of a w-bit lane (w <= 63); only the low w bits of the
    // returned value are meaningful. The signed minimum is returned as the
    // two's-complement pattern 100..0.
    function automatic logic [63:0] sat_bound(input int w, input logic sgn,
                                              input logic upper);
        logic [63:0] one;
        one = 64'd1;
        if (sgn) begin
            return upper ? ((one << (w - 1)) - one) : ~((one << (w - 1)) - one);
        end
        return upper ? ((one << w) - one) : 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/expr_pipe_lanes_lane.sv
`default_nettype none
// ============================================================================
//  Module      : expr_lane
//  Description : Combinational single-lane expression evaluator.
//                i_op  [2:0]   opcode (see expr_pipe_pkg)
//                i_sgn         1 = operands are two's complement
//                i_a, i_b      W-bit operands
//                o_y           W-bit result
//                o_ovf         ADD/SUB/MUL result out of W-bit range
//                Build macro EXPR_PIPE_SAT_EN: overflowing ADD/SUB/MUL clamp
//                to the lane's max/min instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module expr_lane
    import expr_pipe_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [2:0]   i_op,
    input  logic         i_sgn,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y,
    output logic         o_ovf
);

    localparam int c_xw = 2 * W + 1;
    localparam int c_sw = shamt_w(W);
    localparam logic [c_sw-1:0] c_w_amt = c_sw'(W);

    logic [c_xw-1:0] w_ax;
    logic [c_xw-1:0] w_bx;
    logic [c_xw-1:0] w_full;
    logic [c_sw-1:0] w_sh;
    logic            w_sh_big;
    logic            w_lt;
    logic            w_arith;
    logic            w_oor;
    logic [W-1:0]    w_y;

    // Operands extended to full intermediate precision per lane signedness.
    assign w_ax     = {{(W + 1){i_sgn & i_a[W-1]}}, i_a};
    assign w_bx     = {{(W + 1){i_sgn & i_b[W-1]}}, i_b};
    assign w_sh     = i_b[c_sw-1:0];
    assign w_sh_big = (w_sh >= c_w_amt);
    assign w_lt     = i_sgn ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);

    always_comb begin
        w_full  = '0;
        w_arith = 1'b0;
        w_y     = '0;
        case (i_op)
            OP_ADD: begin
                w_full  = w_ax + w_bx;
                w_arith = 1'b1;
                w_y     = w_full[W-1:0];
            end
            OP_SUB: begin
                w_full  = w_ax - w_bx;
                w_arith = 1'b1;
                w_y     = w_full[W-1:0];
            end
            OP_MUL: begin
                w_full  = w_ax * w_bx;
                w_arith = 1'b1;
                w_y     = w_full[W-1:0];
            end
            OP_SHL: w_y = w_sh_big ? '0 : (i_a << w_sh);
            OP_SHR: begin
                if (w_sh_big) begin
                    w_y = {W{i_sgn & i_a[W-1]}};
                end else if (i_sgn) begin
                    w_y = $signed(i_a) >>> w_sh;
                end else begin
                    w_y = i_a >> w_sh;
                end
            end
            OP_LT:   w_y = {{(W - 1){1'b0}}, w_lt};
            OP_XNOR: w_y = i_a ~^ i_b;
            OP_SEL:  w_y = (i_a != '0) ? i_b : ~i_b;
            default: w_y = '0;
        endcase
    end

    // Out of range: unsigned needs all bits above W clear; signed needs the
    // top W+2 bits to be a pure sign extension.
    assign w_oor = i_sgn ? !((&w_full[c_xw-1:W-1]) || (~|w_full[c_xw-1:W-1]))
                         : (|w_full[c_xw-1:W]);
    assign o_ovf = w_arith & w_oor;

`ifdef EXPR_PIPE_SAT_EN
    logic [63:0] w_hi64;
    logic [63:0] w_lo64;
    assign w_hi64 = sat_bound(W, i_sgn, 1'b1);
    assign w_lo64 = sat_bound(W, i_sgn, 1'b0);
    // A negative full-precision result (MSB set) can only overflow downward.
    assign o_y = o_ovf ? (w_full[c_xw-1] ? w_lo64[W-1:0] : w_hi64[W-1:0]) : w_y;
`else
    assign o_y = w_y;
`endif

endmodule
`default_nettype wire

// File: rtl/expr_pipe_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : expr_pipe_lanes
//  Description : LANES independent expression lanes feeding a STAGES-deep
//                elastic valid/ready pipeline plus a completed-output counter.
//                clk, reset        clock, synchronous active-high reset
//                in_valid/in_ready input handshake
//                in_op, in_sgn     per-lane opcode (3 bits) and signed flag
//                in_a, in_b        per-lane W-bit operands, lane 0 in LSBs
//                out_valid/ready   output handshake
//                out_y, out_ovf    per-lane result and overflow flag
//                out_cnt           output handshakes, wraps mod 2^CNT_W
//                Build macro EXPR_PIPE_SAT_EN: saturating ADD/SUB/MUL.
//  Revision    : 1.0 - initial release
// ============================================================================
module expr_pipe_lanes
    import expr_pipe_pkg::*;
#(
    parameter int W      = 6,
    parameter int LANES  = 3,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3*LANES-1:0]   in_op,
    input  logic [LANES-1:0]     in_sgn,
    input  logic [W*LANES-1:0]   in_a,
    input  logic [W*LANES-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*LANES-1:0]   out_y,
    output logic [LANES-1:0]     out_ovf,
    output logic [CNT_W-1:0]     out_cnt
);

    localparam int c_dw = W * LANES;

    logic [c_dw-1:0]   w_lane_y;
    logic [LANES-1:0]  w_lane_ovf;

    logic [STAGES-1:0] r_vld_q;
    logic [STAGES-1:0] w_vld_d;
    logic [c_dw-1:0]   r_y_q   [STAGES];
    logic [c_dw-1:0]   w_y_d   [STAGES];
    logic [LANES-1:0]  r_ovf_q [STAGES];
    logic [LANES-1:0]  w_ovf_d [STAGES];
    logic [STAGES-1:0] w_adv;
    logic              w_adv_up;
    logic              w_fire;
    logic [CNT_W-1:0]  r_cnt_q;
    logic [CNT_W-1:0]  w_cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            expr_lane #(
                .W (W)
            ) u_lane (
                .i_op  (in_op[3*gi +: 3]),
                .i_sgn (in_sgn[gi]),
                .i_a   (in_a[W*gi +: W]),
                .i_b   (in_b[W*gi +: W]),
                .o_y   (w_lane_y[W*gi +: W]),
                .o_ovf (w_lane_ovf[gi])
            );
        end
    endgenerate

    // A stage advances when it is empty or its successor advances; the
    // last stage's successor is the downstream consumer.
    always_comb begin
        w_adv    = '0;
        w_adv_up = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_adv[k] = !r_vld_q[k] || w_adv_up;
            w_adv_up = w_adv[k];
        end
    end

    always_comb begin
        w_vld_d = r_vld_q;
        for (int k = 0; k < STAGES; k++) begin
            w_y_d[k]   = r_y_q[k];
            w_ovf_d[k] = r_ovf_q[k];
        end
        if (w_adv[0]) begin
            w_vld_d[0] = in_valid;
            if (in_valid) begin
                w_y_d[0]   = w_lane_y;
                w_ovf_d[0] = w_lane_ovf;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (w_adv[k]) begin
                w_vld_d[k] = r_vld_q[k-1];
                if (r_vld_q[k-1]) begin
                    w_y_d[k]   = r_y_q[k-1];
                    w_ovf_d[k] = r_ovf_q[k-1];
                end
            end
        end
    end

    assign w_fire  = r_vld_q[STAGES-1] & out_ready;
    assign w_cnt_d = r_cnt_q + {{(CNT_W - 1){1'b0}}, w_fire};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_q <= '0;
            r_cnt_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_y_q[k]   <= '0;
                r_ovf_q[k] <= '0;
            end
        end else begin
            r_vld_q <= w_vld_d;
            r_cnt_q <= w_cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                r_y_q[k]   <= w_y_d[k];
                r_ovf_q[k] <= w_ovf_d[k];
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_vld_q[STAGES-1];
    assign out_y     = r_y_q[STAGES-1];
    assign out_ovf   = r_ovf_q[STAGES-1];
    assign out_cnt   = r_cnt_q;

endmodule
`default_nettype wire
